// File: rtl/ad9203_capture_mc_if.sv
// Pin/stream bundle between the AD9203 capture front-end and its surroundings.
// master = capture block, slave = ADC pins plus the downstream DSP/control side.
interface ad9203_capture_mc_if #(
  parameter int unsigned CH_NUM  = 2,
  parameter int unsigned D_BIT   = 10,
  parameter int unsigned OUT_BIT = 12
);
  logic                        iEN;
  logic                        iDFS;
  logic                        iSAT_EN;
  logic                        iOTR_CLR;
  logic [CH_NUM-1:0]           iOTR;
  logic [CH_NUM*D_BIT-1:0]     iDATA;
  logic                        oCLK;
  logic                        oDFS;
  logic                        oTRI_ST;
  logic                        oSTBY;
  logic [CH_NUM*OUT_BIT-1:0]   oDATA;
  logic                        oVALID;
  logic [CH_NUM-1:0]           oOTR;
  logic [CH_NUM-1:0]           oOTR_STICKY;
  logic                        oREADY;

  modport master (
    input  iEN, iDFS, iSAT_EN, iOTR_CLR, iOTR, iDATA,
    output oCLK, oDFS, oTRI_ST, oSTBY, oDATA, oVALID, oOTR, oOTR_STICKY, oREADY
  );

  modport slave (
    output iEN, iDFS, iSAT_EN, iOTR_CLR, iOTR, iDATA,
    input  oCLK, oDFS, oTRI_ST, oSTBY, oDATA, oVALID, oOTR, oOTR_STICKY, oREADY
  );
endinterface

// File: rtl/ad9203_capture_mc.sv
// Multi-channel AD9203 capture: ADC clock generation, power-up sequencing,
// lockstep sampling, format conversion, optional saturation and sticky OTR.
module ad9203_capture_mc #(
  parameter int unsigned CH_NUM     = 2,
  parameter int unsigned D_BIT      = 10,
  parameter int unsigned OUT_BIT    = 12,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned WAKE_CYC   = 64,
  parameter int unsigned DATA_DELAY = 5
) (
  input logic                 iCLK,
  input logic                 iRST,
  ad9203_capture_mc_if.master bus
);

  localparam int unsigned PW      = $clog2(CLK_DIV);
  localparam int unsigned CNT_MAX = (WAKE_CYC > DATA_DELAY) ? WAKE_CYC : DATA_DELAY;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [D_BIT-1:0] POS_FS = {1'b0, {(D_BIT-1){1'b1}}};
  localparam logic [D_BIT-1:0] NEG_FS = {1'b1, {(D_BIT-1){1'b0}}};

  typedef enum logic [1:0] {S_OFF, S_WAKE, S_FLUSH, S_RUN} state_t;

  state_t                    state_q, state_d;
  logic [PW-1:0]             phase_q, phase_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      clk_q, clk_d;
  logic                      dfs_q, dfs_d;
  logic                      cap_stb_q, cap_stb_d;
  logic [CH_NUM*D_BIT-1:0]   cap_data_q, cap_data_d;
  logic [CH_NUM-1:0]         cap_otr_q, cap_otr_d;
  logic [CH_NUM*OUT_BIT-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic [CH_NUM-1:0]         otr_q, otr_d;
  logic [CH_NUM-1:0]         sticky_q, sticky_d;
  logic                      tick;
  logic [D_BIT-1:0]          raw;
  logic signed [D_BIT-1:0]   s;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= S_OFF;
      phase_q    <= '0;
      cnt_q      <= '0;
      clk_q      <= 1'b0;
      dfs_q      <= 1'b0;
      cap_stb_q  <= 1'b0;
      cap_data_q <= '0;
      cap_otr_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      otr_q      <= '0;
      sticky_q   <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      clk_q      <= clk_d;
      dfs_q      <= dfs_d;
      cap_stb_q  <= cap_stb_d;
      cap_data_q <= cap_data_d;
      cap_otr_q  <= cap_otr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      otr_q      <= otr_d;
      sticky_q   <= sticky_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    dfs_d      = dfs_q;
    cap_stb_d  = 1'b0;
    cap_data_d = cap_data_q;
    cap_otr_d  = cap_otr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    otr_d      = otr_q;
    sticky_d   = sticky_q;
    raw        = '0;
    s          = '0;

    tick = (state_q != S_OFF) && (phase_q == PW'(CLK_DIV - 1));
    if (state_q != S_OFF) phase_d = tick ? '0 : phase_q + 1'b1;
    if (state_q == S_OFF) dfs_d = bus.iDFS;
    if (bus.iOTR_CLR) sticky_d = '0;

    if (!bus.iEN) begin
      state_d = S_OFF;
      phase_d = '0;
      cnt_d   = '0;
    end else begin
      // Second stage: convert the sample latched on the previous tick.
      if (cap_stb_q) begin
        valid_d = 1'b1;
        otr_d   = cap_otr_q;
        for (int unsigned k = 0; k < CH_NUM; k++) begin
          raw = cap_data_q[k*D_BIT +: D_BIT];
          s   = raw;
          s[D_BIT-1] = raw[D_BIT-1] ^ ~dfs_q;
          if (bus.iSAT_EN && cap_otr_q[k]) s = s[D_BIT-1] ? NEG_FS : POS_FS;
          data_d[k*OUT_BIT +: OUT_BIT] = OUT_BIT'(s);
        end
      end

      unique case (state_q)
        S_OFF: state_d = S_WAKE;
        S_WAKE:
          if (tick) begin
            if (cnt_q == CW'(WAKE_CYC - 1)) begin
              state_d = S_FLUSH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        S_FLUSH:
          if (tick) begin
            if (cnt_q == CW'(DATA_DELAY - 1)) begin
              state_d = S_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        S_RUN:
          if (tick) begin
            cap_stb_d  = 1'b1;
            cap_data_d = bus.iDATA;
            cap_otr_d  = bus.iOTR;
            sticky_d   = sticky_d | bus.iOTR;
          end
        default: state_d = S_OFF;
      endcase
    end

    clk_d = (phase_d >= PW'(CLK_DIV / 2));
  end

  assign bus.oCLK        = clk_q;
  assign bus.oDFS        = dfs_q;
  assign bus.oSTBY       = (state_q == S_OFF);
  assign bus.oTRI_ST     = (state_q == S_OFF) || (state_q == S_WAKE);
  assign bus.oREADY      = (state_q == S_RUN);
  assign bus.oDATA       = data_q;
  assign bus.oVALID      = valid_q;
  assign bus.oOTR        = otr_q;
  assign bus.oOTR_STICKY = sticky_q;

endmodule

// File: doc/ad9203_capture_mc.md
Name: ad9203_capture_mc

Overview:
Multi-channel, parametrised capture front-end for AD9203-class pipelined ADCs. It generates the ADC sample clock from the system clock and sequences ADC power-up, output enable and pipeline flush. It captures all channels in lockstep and converts samples to sign-extended two's complement. It also handles per-channel out-of-range, with optional saturation and sticky flags. It sits between the ADC pins and the DSP chain (DDC/filters), replacing the single-mode capture block.

Parameters:
CH_NUM, 2, number of ADCs captured in parallel (>=1)
D_BIT, 10, ADC data width
OUT_BIT, 12, output sample width per channel (>= D_BIT)
CLK_DIV, 4, iCLK cycles per ADC clock period (even, >=2)
WAKE_CYC, 64, ADC clock periods between standby release and output enable (>=1)
DATA_DELAY, 5, ADC pipeline latency in ADC clock periods; samples discarded after output enable (>=1)

Ports:
iCLK  in  1  system clock
iRST  in  1  asynchronous reset, active-high
iEN  in  1  1 = run ADCs; 0 = power down
iDFS  in  1  requested ADC format: 1 = two's complement, 0 = straight binary
iSAT_EN  in  1  1 = clamp out-of-range samples to full scale
iOTR_CLR  in  1  clear sticky OTR flags (single-cycle pulse)
iOTR  in  CH_NUM  per-channel out-of-range from ADC
iDATA  in  CH_NUM*D_BIT  ADC data; channel k at bits [k*D_BIT +: D_BIT]
oCLK  out  1  ADC sample clock, 50% duty
oDFS  out  1  data format pin to ADC
oTRI_ST  out  1  1 = ADC outputs HiZ; 0 = active
oSTBY  out  1  1 = ADC power-down; 0 = normal
oDATA  out  CH_NUM*OUT_BIT  converted samples; channel k at [k*OUT_BIT +: OUT_BIT]
oVALID  out  1  one-cycle strobe; oDATA/oOTR are new
oOTR  out  CH_NUM  OTR registered alongside oDATA
oOTR_STICKY  out  CH_NUM  per-channel sticky OTR
oREADY  out  1  1 while FSM is in RUN

Behaviour:
- Reset values: oSTBY=1, oTRI_ST=1, oCLK=0, oDFS=0, oDATA=0, oVALID=0, oOTR=0, oOTR_STICKY=0, oREADY=0; FSM=OFF; all counters=0.
- Clock generator: phase counter 0..CLK_DIV-1 runs only outside OFF. oCLK=0 for phases 0..CLK_DIV/2-1 and 1 otherwise. An "ADC tick" is the iCLK edge where the phase wraps CLK_DIV-1 -> 0.
- FSM:
  - OFF: oSTBY=1, oTRI_ST=1, oCLK=0. oDFS latches iDFS each cycle. Goes to WAKE when iEN=1.
  - WAKE: oSTBY=0, clock running, oTRI_ST=1. Goes to FLUSH after WAKE_CYC ticks.
  - FLUSH: oTRI_ST=0. Samples are not captured. Goes to RUN after DATA_DELAY ticks.
  - RUN: oREADY=1. Every tick, all channels' iDATA/iOTR are captured. oVALID=1 on the next iCLK cycle only.
  - In any state, iEN=0 -> OFF on the next edge: counters cleared, oCLK=0, oVALID=0. oDATA holds its last value.
- oDFS is frozen outside OFF. Changing iDFS mid-run has no effect until the block re-enters OFF.
- Conversion per channel (format = oDFS):
  - s = raw if oDFS=1; raw with MSB inverted if oDFS=0.
  - s is sign-extended from D_BIT to OUT_BIT.
- Saturation: if iSAT_EN=1 and the captured OTR=1, the output is forced to a full-scale value chosen by the sign of s:
  - s MSB=0 -> +(2^(D_BIT-1)-1)
  - s MSB=1 -> -2^(D_BIT-1)
  - The result is then sign-extended.
  - With iSAT_EN=0, s passes unchanged.
- oOTR is updated with oDATA. It holds between strobes.
- Sticky flags:
  - oOTR_STICKY[k] sets on any RUN capture with iOTR[k]=1.
  - iOTR_CLR clears all flags.
  - If set and clear occur in the same cycle, set wins.
  - Flags persist through OFF and are cleared only by reset or iOTR_CLR.
- Latency: capture tick -> oDATA/oVALID valid 1 iCLK later. Steady-state oVALID period = CLK_DIV cycles.
- First oVALID: exactly (WAKE_CYC+DATA_DELAY+1)*CLK_DIV+1 iCLK cycles after the edge where iEN=1 is sampled in OFF.

Test Plan:
1. Assert iRST mid-RUN, asynchronously -> all outputs immediately at reset values. After release with iEN=0 -> oSTBY=1, oTRI_ST=1, oCLK stays 0.
2. CLK_DIV=4, WAKE_CYC=8, DATA_DELAY=3, iEN=1 -> oSTBY falls next cycle; oTRI_ST falls after 32 cycles; first oVALID at cycle 49; then oVALID every 4 cycles; oCLK period 4 at 50% duty.
3. D_BIT=10, OUT_BIT=12, iDFS=0:
   - iDATA=10'h000 -> 12'hE00
   - 10'h3FF -> 12'h1FF
   - 10'h200 -> 12'h000
   With iDFS=1: 10'h200 -> 12'hE00. Also change iDFS during RUN -> oDFS and conversion unchanged.
4. iSAT_EN=1, DFS=1:
   - iDATA=10'h1F0 with OTR=1 -> oDATA=12'h1FF, oOTR=1
   - 10'h210 with OTR=1 -> 12'hE00
   With iSAT_EN=0: same samples pass through unclamped.
5. Channel 1 OTR pulse -> oOTR_STICKY=2'b10. Then iOTR_CLR coinciding with a new OTR capture -> flag stays 1. Then iOTR_CLR alone -> 0.
6. Drop iEN mid-RUN -> next cycle FSM=OFF, oVALID=0, oSTBY=1, oTRI_ST=1, oCLK=0, oDATA held. Re-enable -> full WAKE/FLUSH sequence repeats with the timing of scenario 2.
